tree_adder_sequencer: RTL and testbench

- Control stage directly upstream of the tree adder element array. It drives the shared command bus that every 2x2 element samples.
- Per request it issues one top-load command from the selected source, then GRID_LOG2-1 sum-decimate commands.
- It then captures the collapsed total from the top-left element's sum output, optionally adds it to the previous result, and presents it on a valid/ready handshake.

---
 rtl/tree_adder_pkg.sv | 37 +++
 rtl/tree_adder_sequencer.sv | 101 ++++++++++
 tb/tb_tree_adder_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tree_adder_pkg.sv
// rtl/tree_adder_pkg.sv - shared command codes, source and state enums for the tree adder
package tree_adder_pkg;

  // Command codes broadcast on the element command bus
  localparam logic [3:0] CMD_NOP              = 4'd0;
  localparam logic [3:0] CMD_TOPLOAD_SHADOW_A = 4'd9;
  localparam logic [3:0] CMD_TOPLOAD_SHADOW_B = 4'd10;
  localparam logic [3:0] CMD_SUMDECIMATE      = 4'd11;
  localparam logic [3:0] CMD_TOPLOAD_MULT     = 4'd12;

  // Selectable top-load sources; encoding 3 is reserved and rejected
  typedef enum logic [1:0] {
    SRC_MULT = 2'd0,
    SRC_SHA  = 2'd1,
    SRC_SHB  = 2'd2
  } src_e;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DECIM = 3'd2,
    CAPT  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // Top-load command for a given source
  function automatic logic [3:0] load_code(input src_e src);
    case (src)
      SRC_MULT: load_code = CMD_TOPLOAD_MULT;
      SRC_SHA:  load_code = CMD_TOPLOAD_SHADOW_A;
      SRC_SHB:  load_code = CMD_TOPLOAD_SHADOW_B;
      default:  load_code = CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/tree_adder_sequencer.sv
// rtl/tree_adder_sequencer.sv - drives the element command bus and collects the reduced total
module tree_adder_sequencer
  import tree_adder_pkg::*;
#(
  parameter int ADDER_DATASIZE = 16,
  parameter int CMD_WIDTH      = 4,
  parameter int GRID_LOG2      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                src_sel,
  input  logic                      acc_mode,
  output logic                      ready,
  output logic [CMD_WIDTH-1:0]      cmd,
  input  logic [ADDER_DATASIZE-1:0] sum_in,
  output logic [ADDER_DATASIZE-1:0] result,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic                      err
);

  // Step counter only needs to reach GRID_LOG2-1 (at most 7)
  localparam int         STEP_W    = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(GRID_LOG2 - 1);
  localparam logic [2:0] SRC_ILLEGAL = 3'd3;

  state_e            state;
  logic [STEP_W-1:0] step;
  logic              acc_q;

  // Single FSM register; cmd and ready are loaded with the value for the
  // state being entered so the bus is driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= '0;
      acc_q        <= 1'b0;
      cmd          <= '0;
      ready        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, src_sel} == SRC_ILLEGAL) begin
              err <= 1'b1;
            end else begin
              // The load command register holds the latched source for LOAD
              acc_q <= acc_mode;
              cmd   <= CMD_WIDTH'(load_code(src_e'(src_sel)));
              ready <= 1'b0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (GRID_LOG2 > 1) begin
            step  <= STEP_W'(1);
            cmd   <= CMD_WIDTH'(CMD_SUMDECIMATE);
            state <= DECIM;
          end else begin
            cmd   <= CMD_WIDTH'(CMD_NOP);
            state <= CAPT;
          end
        end
        DECIM: begin
          if (step == LAST_STEP) begin
            cmd   <= CMD_WIDTH'(CMD_NOP);
            state <= CAPT;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        CAPT: begin
          // Accumulation deliberately wraps modulo 2^ADDER_DATASIZE
          result       <= acc_q ? (result + sum_in) : sum_in;
          result_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            ready        <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          cmd          <= CMD_WIDTH'(CMD_NOP);
          ready        <= 1'b1;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_adder_sequencer.sv
// tb/tb_tree_adder_sequencer.sv - directed self-checking bench for tree_adder_sequencer
module tb_tree_adder_sequencer;

  localparam int G = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [1:0]  src_sel = 2'd0;
  logic        acc_mode = 1'b0;
  logic [15:0] sum_in = 16'hDEAD;
  logic        result_ready = 1'b0;

  logic        ready, ready1;
  logic [3:0]  cmd, cmd1;
  logic [15:0] result, result1;
  logic        result_valid, result_valid1;
  logic        err, err1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tree_adder_sequencer #(.ADDER_DATASIZE(16), .CMD_WIDTH(4), .GRID_LOG2(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_sel(src_sel), .acc_mode(acc_mode),
    .ready(ready), .cmd(cmd), .sum_in(sum_in), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .err(err)
  );

  tree_adder_sequencer #(.ADDER_DATASIZE(16), .CMD_WIDTH(4), .GRID_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .src_sel(src_sel), .acc_mode(acc_mode),
    .ready(ready1), .cmd(cmd1), .sum_in(sum_in), .result(result1),
    .result_valid(result_valid1), .result_ready(result_ready), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the GRID_LOG2=3 instance, leaving it in HOLD
  task automatic run_op(input logic [1:0] src, input logic acc, input logic [15:0] sumv,
                        input logic [3:0] exp_load, input logic [15:0] exp_res);
    src_sel  = src;
    acc_mode = acc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    src_sel  = 2'(~src);
    acc_mode = ~acc;
    check("load_cmd", cmd, exp_load);
    check("load_ready", ready, 1'b0);
    for (int i = 1; i < G; i++) begin
      tick();
      check("decim_cmd", cmd, 4'd11);
      check("decim_ready", ready, 1'b0);
    end
    tick();
    check("capt_cmd", cmd, 4'd0);
    check("capt_valid", result_valid, 1'b0);
    sum_in = sumv;
    tick();
    sum_in = 16'hDEAD;
    check("hold_valid", result_valid, 1'b1);
    check("hold_result", result, exp_res);
    check("hold_ready", ready, 1'b0);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("consume_valid", result_valid, 1'b0);
    check("consume_ready", ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_cmd", cmd, 4'd0);
    check("rst_result", result, 16'h0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", ready, 1'b1);
    rst_n = 1'b1;
    tick();
    check("idle_ready", ready, 1'b1);

    // Basic multiplier load
    run_op(2'd0, 1'b0, 16'h0123, 4'd12, 16'h0123);
    consume();

    // Shadow sources
    run_op(2'd1, 1'b0, 16'h1111, 4'd9, 16'h1111);
    consume();
    run_op(2'd2, 1'b0, 16'h2222, 4'd10, 16'h2222);
    consume();

    // Accumulate with wrap
    run_op(2'd0, 1'b0, 16'hFFF0, 4'd12, 16'hFFF0);
    consume();
    run_op(2'd0, 1'b1, 16'h0020, 4'd12, 16'h0010);

    // Backpressure with an ignored start in HOLD
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      src_sel = (i == 2) ? 2'd3 : 2'd0;
      tick();
      check("bp_valid", result_valid, 1'b1);
      check("bp_result", result, 16'h0010);
      check("bp_cmd", cmd, 4'd0);
      check("bp_err", err, 1'b0);
      check("bp_ready", ready, 1'b0);
    end
    start = 1'b0;
    consume();
    tick();
    check("post_bp_cmd", cmd, 4'd0);

    // Illegal source
    src_sel = 2'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("ill_err", err, 1'b1);
    check("ill_cmd", cmd, 4'd0);
    check("ill_ready", ready, 1'b1);
    tick();
    check("ill_err_drop", err, 1'b0);
    check("ill_ready2", ready, 1'b1);

    // Accumulate uses result already consumed (0x0010)
    run_op(2'd1, 1'b1, 16'h0005, 4'd9, 16'h0015);
    consume();

    // Asynchronous reset during DECIM
    src_sel = 2'd0;
    acc_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_cmd", cmd, 4'd11);
    rst_n = 1'b0;
    #1;
    check("arst_cmd", cmd, 4'd0);
    check("arst_valid", result_valid, 1'b0);
    check("arst_ready", ready, 1'b1);
    check("arst_result", result, 16'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("after_rst_cmd", cmd, 4'd0);

    // GRID_LOG2=1 instance: 12 then 0, valid two cycles after accept
    src_sel  = 2'd0;
    acc_mode = 1'b0;
    start1   = 1'b1;
    tick();
    start1   = 1'b0;
    check("g1_load_cmd", cmd1, 4'd12);
    check("g1_ready", ready1, 1'b0);
    tick();
    check("g1_capt_cmd", cmd1, 4'd0);
    check("g1_capt_valid", result_valid1, 1'b0);
    sum_in = 16'h4567;
    tick();
    sum_in = 16'hDEAD;
    check("g1_valid", result_valid1, 1'b1);
    check("g1_result", result1, 16'h4567);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("g1_consume_valid", result_valid1, 1'b0);
    check("g1_consume_ready", ready1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
